// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-2 message schedule generator (SHA-224/256 or SHA-384/512).
//   Loads one 16-word block, then emits W[0..ROUNDS-1], one word per accepted
//   output transfer. The schedule is computed in place in a 16-word sliding window.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_word     message word input (W[0] first)
//   w_valid/w_ready/w_out         schedule word output
//   w_idx                         round index of w_out
//   w_last                        w_out is W[ROUNDS-1]
//   busy                          block is emitting words (RUN state)

// Small sigma: rotr(R1) ^ rotr(R2) ^ shr(SH), all amounts fixed at elaboration.
module sha2_sigma #(
  parameter int W  = 32,
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int SH = 3
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = {x[R1-1:0], x[W-1:R1]} ^ {x[R2-1:0], x[W-1:R2]} ^ (x >> SH);
endmodule

module sha2_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [6:0]        w_idx,
  output logic              w_last,
  output logic              busy
);

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
    $error("sha2_msg_sched: ROUNDS must be in 16..127");
  end

  localparam bit W64   = (WORD_W == 64);
  localparam int S0_R1 = W64 ? 1  : 7;
  localparam int S0_R2 = W64 ? 8  : 18;
  localparam int S0_SH = W64 ? 7  : 3;
  localparam int S1_R1 = W64 ? 19 : 17;
  localparam int S1_R2 = W64 ? 61 : 19;
  localparam int S1_SH = W64 ? 6  : 10;

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] win [16];
  logic [6:0]        cnt;
  logic [WORD_W-1:0] s0_v, s1_v, w_new;
  logic              in_xfer, out_xfer, cnt_last;

  sha2_sigma #(.W(WORD_W), .R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (.x(win[1]),  .y(s0_v));
  sha2_sigma #(.W(WORD_W), .R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (.x(win[14]), .y(s1_v));

  // win[0] holds W[t]; the word entering at the top is W[t+16].
  assign w_new    = s1_v + win[9] + s0_v + win[0];

  assign in_xfer  = (state_q == LOAD) && in_valid;
  assign out_xfer = (state_q == RUN) && w_ready;
  assign cnt_last = (cnt == 7'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (in_xfer && cnt == 7'd15) state_d = RUN;
      RUN:  if (out_xfer && cnt_last)    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (in_xfer) begin
      win[cnt[3:0]] <= in_word;
      cnt           <= (cnt == 7'd15) ? 7'd0 : cnt + 7'd1;
    end else if (out_xfer) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      cnt     <= cnt_last ? 7'd0 : cnt + 7'd1;
    end
  end

  // Outputs depend only on registered state, never on w_ready. Data outputs
  // are gated to zero outside RUN so the load counter is not exposed.
  assign in_ready = (state_q == LOAD);
  assign w_valid  = (state_q == RUN);
  assign busy     = w_valid;
  assign w_out    = w_valid ? win[0] : '0;
  assign w_idx    = w_valid ? cnt : '0;
  assign w_last   = w_valid && cnt_last;

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Self-checking bench for sha2_msg_sched: one 32-bit/64-round instance and one
// 64-bit/80-round instance, checked against an array-based schedule model.
module tb_sha2_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv32, ir32, wv32, wr32, wl32, b32;
  logic [31:0] iw32, wo32;
  logic [6:0]  wi32;
  logic        iv64, ir64, wv64, wr64, wl64, b64;
  logic [63:0] iw64, wo64;
  logic [6:0]  wi64;

  sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_word(iw32),
    .w_valid(wv32), .w_ready(wr32), .w_out(wo32), .w_idx(wi32), .w_last(wl32), .busy(b32));

  sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_word(iw64),
    .w_valid(wv64), .w_ready(wr64), .w_out(wo64), .w_idx(wi64), .w_last(wl64), .busy(b64));

  typedef logic [63:0] blk_t [16];
  typedef struct { bit s64; int idx; logic [63:0] exp; } vec_t;

  int          pass_cnt = 0, tot_cnt = 0;
  logic [63:0] got [128];
  int          n_got;
  logic [63:0] ref_w [128];
  logic [63:0] save [128];
  logic [63:0] abc32 [128], abc64 [128];
  vec_t        vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---- reference model: textbook recurrence over a full array ----
  function automatic logic [63:0] rotr(logic [63:0] x, int r, bit s64);
    int wd = s64 ? 64 : 32;
    logic [63:0] m = s64 ? '1 : 64'hFFFF_FFFF;
    return ((x >> r) | (x << (wd - r))) & m;
  endfunction

  function automatic logic [63:0] sg0(logic [63:0] x, bit s64);
    return s64 ? rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7)
               : rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sg1(logic [63:0] x, bit s64);
    return s64 ? rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6)
               : rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
  endfunction

  task automatic ref_sched(input bit s64, input blk_t m);
    logic [63:0] msk = s64 ? '1 : 64'hFFFF_FFFF;
    for (int t = 0; t < 16; t++) ref_w[t] = m[t] & msk;
    for (int t = 16; t < 128; t++)
      ref_w[t] = (sg1(ref_w[t-2], s64) + ref_w[t-7] + sg0(ref_w[t-15], s64) + ref_w[t-16]) & msk;
  endtask

  task automatic cmp_model(input string nm, input bit s64, input blk_t m);
    int bad = 0;
    ref_sched(s64, m);
    for (int t = 0; t < (s64 ? 80 : 64); t++) if (got[t] !== ref_w[t]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  // ---- stimulus ----
  task automatic drive(input bit s64, input bit iv, input logic [63:0] iw, input bit wr);
    if (s64) begin
      iv64 = iv; iw64 = iw; wr64 = wr; iv32 = 1'b0; iw32 = '0; wr32 = 1'b1;
    end else begin
      iv32 = iv; iw32 = iw[31:0]; wr32 = wr; iv64 = 1'b0; iw64 = '0; wr64 = 1'b1;
    end
  endtask

  task automatic load(input bit s64, input blk_t m, input bit gaps);
    int i = 0, cyc = 0, bad = 0;
    bit v;
    while (i < 16 && cyc < 2000) begin
      @(negedge clk); cyc++;
      v = gaps ? ($urandom % 3 != 0) : 1'b1;
      drive(s64, v, v ? m[i] : {$urandom, $urandom}, 1'b1);
      if (s64 ? wv64 : wv32) bad++;
      if (v && (s64 ? ir64 : ir32)) i++;
    end
    chk("load_count", 64'(i), 64'd16);
    chk("load_wvalid_low", 64'(bad), 64'd0);
  endtask

  task automatic collect(input bit s64, input bit stall, input bit junk, input int abort_at);
    int rounds = s64 ? 80 : 64;
    int cyc = 0, bad_idx = 0, bad_last = 0, bad_stab = 0, bad_rdy = 0;
    bit done = 0, aborted = 0, prev_stall = 0, wr;
    logic wv, wl, ir, bz;
    logic [63:0] wo, po;
    logic [6:0]  wi, pi;
    n_got = 0; po = '0; pi = '0;
    while (!done && cyc < 5000) begin
      @(negedge clk); cyc++;
      wv = s64 ? wv64 : wv32; wl = s64 ? wl64 : wl32; ir = s64 ? ir64 : ir32;
      wo = s64 ? wo64 : 64'(wo32); wi = s64 ? wi64 : wi32;
      if (cyc == 1) chk("first_word_valid", 64'(wv), 64'd1);
      if (ir) bad_rdy++;
      if (prev_stall && (wo !== po || wi !== pi)) bad_stab++;
      if (abort_at >= 0 && wv && int'(wi) == abort_at) begin
        rst = 1'b1;
        drive(s64, junk, {$urandom, $urandom}, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(s64, 1'b0, '0, 1'b1);
        wv = s64 ? wv64 : wv32; ir = s64 ? ir64 : ir32; bz = s64 ? b64 : b32;
        wo = s64 ? wo64 : 64'(wo32); wi = s64 ? wi64 : wi32; wl = s64 ? wl64 : wl32;
        chk("abort_wvalid", 64'(wv), 64'd0);
        chk("abort_in_ready", 64'(ir), 64'd1);
        chk("abort_outs", {wo[31:0], 8'(wi), 7'd0, wl, 7'd0, bz, 8'd0}, 64'd0);
        done = 1; aborted = 1;
      end else begin
        wr = stall ? 1'($urandom % 2) : 1'b1;
        drive(s64, junk, {$urandom, $urandom}, wr);
        if (wv && wr) begin
          got[n_got] = wo;
          if (int'(wi) != n_got) bad_idx++;
          if (wl != (n_got == rounds - 1)) bad_last++;
          n_got++;
          if (wl || n_got >= rounds) done = 1;
        end
        prev_stall = wv && !wr; po = wo; pi = wi;
      end
    end
    chk("in_ready_low_in_run", 64'(bad_rdy), 64'd0);
    chk("stall_stable", 64'(bad_stab), 64'd0);
    chk("w_idx_seq", 64'(bad_idx), 64'd0);
    if (!aborted) begin
      chk("w_last_pos", 64'(bad_last), 64'd0);
      chk("word_count", 64'(n_got), 64'(rounds));
      @(negedge clk);
      chk("in_ready_after_last", 64'(s64 ? ir64 : ir32), 64'd1);
      chk("wvalid_after_last", 64'(s64 ? wv64 : wv32), 64'd0);
      drive(s64, 1'b0, '0, 1'b1);
    end
  endtask

  blk_t m_abc32, m_abc64, m_rnd;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin m_abc32[i] = '0; m_abc64[i] = '0; end
    m_abc32[0] = 64'h6162_6380;          m_abc32[15] = 64'h18;
    m_abc64[0] = 64'h6162_6380_0000_0000; m_abc64[15] = 64'h18;

    vt[0] = '{0, 0,  64'h6162_6380};
    vt[1] = '{0, 15, 64'h18};
    vt[2] = '{0, 16, 64'h6162_6380};
    vt[3] = '{0, 17, 64'h000F_0000};
    vt[4] = '{1, 0,  64'h6162_6380_0000_0000};
    vt[5] = '{1, 15, 64'h18};
    vt[6] = '{1, 16, 64'h6162_6380_0000_0000};
    vt[7] = '{1, 17, 64'h0003_0000_0000_00C0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready32", 64'(ir32), 64'd1);
    chk("rst_outs32", {wo32, 8'(wi32), 6'd0, wv32, wl32, 7'd0, b32, 8'd0}, 64'd0);
    chk("rst_in_ready64", 64'(ir64), 64'd1);
    chk("rst_outs64", {wo64[63:8], wv64, wl64, b64, 5'(wi64)} | 64'(wo64[7:0]), 64'd0);
    rst = 1'b0;

    // "abc" blocks, both widths
    load(1'b0, m_abc32, 1'b0); collect(1'b0, 1'b0, 1'b0, -1);
    cmp_model("abc32_model", 1'b0, m_abc32); abc32 = got;
    load(1'b1, m_abc64, 1'b0); collect(1'b1, 1'b0, 1'b0, -1);
    cmp_model("abc64_model", 1'b1, m_abc64); abc64 = got;
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec%0d", i), vt[i].s64 ? abc64[vt[i].idx] : abc32[vt[i].idx], vt[i].exp);

    // random block: clean run, then stalls + input gaps + RUN-time input junk
    for (int i = 0; i < 16; i++) m_rnd[i] = 64'($urandom);
    load(1'b0, m_rnd, 1'b0); collect(1'b0, 1'b0, 1'b0, -1);
    cmp_model("rnd32_model", 1'b0, m_rnd); save = got;
    load(1'b0, m_rnd, 1'b1); collect(1'b0, 1'b1, 1'b1, -1);
    begin
      int bad = 0;
      for (int t = 0; t < 64; t++) if (got[t] !== save[t]) bad++;
      chk("stall_seq_equal", 64'(bad), 64'd0);
    end

    // random 64-bit block with stalls
    for (int i = 0; i < 16; i++) m_rnd[i] = {$urandom, $urandom};
    load(1'b1, m_rnd, 1'b1); collect(1'b1, 1'b1, 1'b1, -1);
    cmp_model("rnd64_model", 1'b1, m_rnd);

    // partial load of 9 words waits, then reset discards it
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); drive(1'b0, 1'b1, 64'($urandom), 1'b1);
    end
    begin
      int bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk); drive(1'b0, 1'b0, '0, 1'b1);
        if (wv32 || !ir32) bad++;
      end
      chk("partial_wait", 64'(bad), 64'd0);
    end
    rst = 1'b1; drive(1'b0, 1'b1, 64'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b0; drive(1'b0, 1'b0, '0, 1'b1);
    chk("rst_load_wvalid", 64'(wv32), 64'd0);
    chk("rst_load_in_ready", 64'(ir32), 64'd1);
    load(1'b0, m_abc32, 1'b0); collect(1'b0, 1'b0, 1'b0, -1);
    cmp_model("after_rst_load", 1'b0, m_abc32);

    // reset in RUN at w_idx=30, then a fresh block
    load(1'b0, m_abc32, 1'b0); collect(1'b0, 1'b0, 1'b1, 30);
    begin
      int bad = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (wv32) bad++; end
      chk("no_word_after_rst", 64'(bad), 64'd0);
    end
    load(1'b0, m_abc32, 1'b0); collect(1'b0, 1'b0, 1'b0, -1);
    cmp_model("after_rst_run", 1'b0, m_abc32);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sha2_msg_sched.md
SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
REQ-001 Parameter WORD_W, default 32, SHA-2 word width; only 32 (SHA-224/256) or 64 (SHA-384/512) is legal.
REQ-002 Parameter ROUNDS, default 64, number of schedule words emitted per block; legal range 16..127 (SHA-512 uses 80).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_word carries a message word.
REQ-006 in_ready  output  1  block accepts a message word this cycle.
REQ-007 in_word  input  WORD_W  message word, big-endian word order, W[0] first.
REQ-008 w_valid  output  1  w_out holds a schedule word.
REQ-009 w_ready  input  1  consumer accepts w_out this cycle.
REQ-010 w_out  output  WORD_W  schedule word W[t].
REQ-011 w_idx  output  7  round index t of w_out.
REQ-012 w_last  output  1  high while w_out is W[ROUNDS-1].
REQ-013 busy  output  1  high in RUN state.

Function
REQ-014 Handshake rule: an input transfer occurs when in_valid&in_ready; an output transfer occurs when w_valid&w_ready.
REQ-015 The FSM has two states: LOAD and RUN. Reset enters LOAD.
REQ-016 The datapath holds a 16-entry window win[0..15] and a 7-bit counter cnt.
REQ-017 In LOAD: in_ready=1, w_valid=0; each input transfer writes in_word to win[cnt] and increments cnt.
REQ-018 On the input transfer with cnt=15: cnt clears to 0 and the state moves to RUN on the next cycle, with no idle cycle in between.
REQ-019 In RUN: in_ready=0, w_valid=1, w_out=win[0], w_idx=cnt, w_last=(cnt==ROUNDS-1); these are register-driven with no combinational path from w_ready.
REQ-020 On each output transfer in RUN: win[i] <= win[i+1] for i=0..14, and win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], with the sum taken modulo 2^WORD_W; cnt increments.
REQ-021 For WORD_W=32: s0(x)=ROTR7^ROTR18^SHR3 and s1(x)=ROTR17^ROTR19^SHR10.
REQ-022 For WORD_W=64: s0(x)=ROTR1^ROTR8^SHR7 and s1(x)=ROTR19^ROTR61^SHR6.
REQ-023 Rotation and shift amounts are selected at elaboration from WORD_W, with no runtime mux.
REQ-024 Latency: W[0] is valid the cycle after the 16th input transfer; thereafter one word per cycle while w_ready=1; throughput is 16+ROUNDS cycles per block when there is no backpressure.
REQ-025 Backpressure: while w_ready=0 in RUN, win, cnt, w_out and w_idx hold stable.
REQ-026 On the output transfer with w_last=1: cnt clears to 0 and the state moves to LOAD; in_ready rises on the next cycle, not the same cycle.
REQ-027 In LOAD with in_valid=0, all state holds; a partial load (cnt 1..15) waits indefinitely.
REQ-028 Input traffic in RUN is ignored: no state change occurs and in_ready stays 0.
REQ-029 An illegal WORD_W, or ROUNDS outside 16..127, shall stop elaboration with an error.

Reset
REQ-030 When rst=1 at a clock edge: state=LOAD, cnt=0, all win entries=0, in_ready=1 from the following cycle, w_valid=0, w_out=0, w_idx=0, w_last=0, busy=0.
REQ-031 Reset during LOAD or RUN aborts the block immediately; partially loaded or emitted data is discarded and no word is emitted after reset.
REQ-032 rst has priority over any simultaneous handshake in the same cycle.

Verification
REQ-033 WORD_W=32, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> 64 words emitted; W16=0x61626380, W17=0x000F0000; all words match the reference model; w_last asserts only at w_idx=63.
REQ-034 WORD_W=64, ROUNDS=80, W0=0x6162638000000000, W15=0x18, others 0 -> W16=0x6162638000000000, W17=0x00030000000000C0; 80 words emitted, with w_last at w_idx=79.
REQ-035 WORD_W=32, random w_ready (50%) plus random in_valid gaps -> the emitted word sequence is identical to the no-stall run; w_out and w_idx are stable during every stall cycle.
REQ-036 Two back-to-back blocks -> in_ready=0 throughout RUN; in_ready=1 exactly one cycle after the W[63] transfer; the second block's W0 appears at w_idx=0.
REQ-037 rst asserted after 9 input words, and separately at w_idx=30 -> next cycle w_valid=0, cnt=0, in_ready=1; a fresh "abc" block then produces a correct schedule.
REQ-038 in_valid held high with random data during RUN -> the output sequence is unaffected.
